key_off_cfg_arbiter: RTL and testbench
======================================

// Module: key_off_cfg_arbiter
// PURPOSE
//  Shares the write ports of the per-stage key-extract offset RAMs between two config requesters:
//  req0 = AXI-Lite control-plane writer, req1 = in-band config-packet parser.
//  Round-robin arbitration, one entry write per cycle, lock support for atomic per-tenant bursts,
//  lock timeout, stage-index checking. Outputs feed each stage's key_off_entry_in/_valid/_addr.
// PARAMETERS
//  N_STAGE            5   number of match stages (one-hot write valid width)
//  AXIL_WIDTH         32  config data width
//  KEY_OFF            18  meaningful offset-entry bits; data[AXIL_WIDTH-1:KEY_OFF] forced to 0 on output
//  KEY_OFF_ADDR_WIDTH 4   offset-RAM address width (tenant/vlan index)
//  STAGE_ID_WIDTH     3   stage-select field width
//  LOCK_TMO           255 idle cycles a locked owner may stall before forced release (8-bit counter)
// PORTS
//  clk                  in   1                   clock
//  rst                  in   1                   synchronous reset, active-high
//  reqN_valid (N=0,1)   in   1                   write request valid
//  reqN_ready           out  1                   request accepted this cycle when valid&ready
//  reqN_stage           in   STAGE_ID_WIDTH      target stage
//  reqN_addr            in   KEY_OFF_ADDR_WIDTH  RAM entry address
//  reqN_data            in   AXIL_WIDTH          entry data
//  reqN_lock            in   1                   keep grant after this beat
//  key_off_entry_out    out  AXIL_WIDTH          broadcast write data (registered)
//  key_off_addr_out     out  KEY_OFF_ADDR_WIDTH  broadcast write address (registered)
//  key_off_valid_out    out  N_STAGE             one-hot write strobe, bit = stage
//  cur_owner            out  2                   00 none, 01 req0 locked, 10 req1 locked
//  err_bad_stage        out  1                   sticky: beat with stage >= N_STAGE
//  err_lock_tmo         out  1                   sticky: lock forcibly released
//  err_clr              in   1                   clears both sticky errors
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr=0 (req0 preferred first), tmo_cnt=0.
//  States: IDLE, LOCK0, LOCK1.
//  IDLE: exactly one of reqN_ready high when any valid; both valid -> grant rr_ptr side; one valid -> it.
//    Accepted beat with lock=0: rr_ptr <= other requester. lock=1: go LOCKn, rr_ptr unchanged.
//  LOCKn: only reqn_ready=1 (other held off, ready=0). Accepted beat lock=0 -> IDLE, rr_ptr <= other.
//    tmo_cnt increments each cycle reqn_valid=0, resets to 0 on any accepted beat;
//    tmo_cnt reaches LOCK_TMO -> IDLE, err_lock_tmo<=1, rr_ptr <= other, tmo_cnt <= 0.
//  reqN_ready is combinational from state/valids; never high during rst.
//  Write latency 1: beat accepted at cycle T -> key_off_*_out valid at T+1 for exactly 1 cycle;
//    key_off_valid_out = 0 in cycles with no accepted beat; data/addr hold last value.
//  Bad stage: beat still accepted (ready high), no strobe, err_bad_stage<=1, lock semantics still apply.
//  err_clr same cycle as new error set -> error stays 1 (set wins).
//  Reset mid-lock: returns to IDLE next cycle, no strobe emitted for beat presented during rst.
//  Back-to-back: one write per cycle sustained; alternating when both continuously valid, unlocked.
// CONFIGURATION
//  KEY_OFF_WR_CNT_EN defined: adds outputs wr_cnt0/wr_cnt1 (16b each), count strobed writes per
//    requester (bad-stage beats excluded), wrap 0xFFFF->0, cleared by rst and err_clr.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Both valid, lock=0, 4 cycles: grants req0,req1,req0,req1; strobes 1 cycle later, one per cycle.
//  2 req1 stage=2 addr=5 data=0xFFFF_FFFF -> next cycle valid_out=5'b00100, addr=5, entry=0x0003_FFFF.
//  3 req0 lock=1 x3 beats, lock=0 4th while req1 valid -> req1_ready=0 until after 4th; cur_owner=01.
//  4 req0 locks then drops valid 255 cycles -> err_lock_tmo=1, cur_owner=00, req1 granted next cycle.
//  5 req0 stage=7 -> ready=1, valid_out=0, err_bad_stage=1; err_clr with stage=6 beat -> flag stays 1.
//  6 rst during LOCK1 -> outputs 0, IDLE; with KEY_OFF_WR_CNT_EN, 3 good+1 bad req0 beats -> wr_cnt0=3.

Source files
------------

// File: rtl/key_off_cfg_arbiter.sv
// key_off_cfg_arbiter
//   Shares the write ports of the per-stage key-extract offset RAMs between two config
//   requesters: req0 (AXI-Lite control-plane writer) and req1 (in-band config-packet parser).
//   Round-robin arbitration with one entry write per cycle. A requester can lock the grant for
//   an atomic per-tenant burst. A locked owner that stalls too long is forcibly released.
//   Beats that target a non-existent stage are accepted but produce no write strobe.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   reqN_valid/ready       request handshake (N = 0, 1); a beat is accepted when valid & ready
//   reqN_stage/addr/data   target stage, RAM entry address and entry data of the beat
//   reqN_lock              keep the grant after this beat
//   key_off_entry_out      registered broadcast write data (bits above KEY_OFF forced to 0)
//   key_off_addr_out       registered broadcast write address
//   key_off_valid_out      registered one-hot write strobe, bit index = stage
//   cur_owner              00 none, 01 req0 holds lock, 10 req1 holds lock
//   err_bad_stage          sticky: a beat arrived with stage >= N_STAGE
//   err_lock_tmo           sticky: a lock was forcibly released
//   err_clr                clears both sticky errors (a same-cycle new error still sets)
//
// Optional feature (macro KEY_OFF_WR_CNT_EN)
//   When defined, adds wr_cnt0/wr_cnt1: 16-bit wrapping counts of strobed writes per requester.
//   Bad-stage beats are not counted. Cleared by rst and err_clr.

module key_off_cfg_arbiter #(
  parameter int unsigned N_STAGE            = 5,
  parameter int unsigned AXIL_WIDTH         = 32,
  parameter int unsigned KEY_OFF            = 18,
  parameter int unsigned KEY_OFF_ADDR_WIDTH = 4,
  parameter int unsigned STAGE_ID_WIDTH     = 3,
  parameter int unsigned LOCK_TMO           = 255
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [STAGE_ID_WIDTH-1:0]     req0_stage,
  input  logic [KEY_OFF_ADDR_WIDTH-1:0] req0_addr,
  input  logic [AXIL_WIDTH-1:0]         req0_data,
  input  logic                          req0_lock,

  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [STAGE_ID_WIDTH-1:0]     req1_stage,
  input  logic [KEY_OFF_ADDR_WIDTH-1:0] req1_addr,
  input  logic [AXIL_WIDTH-1:0]         req1_data,
  input  logic                          req1_lock,

  output logic [AXIL_WIDTH-1:0]         key_off_entry_out,
  output logic [KEY_OFF_ADDR_WIDTH-1:0] key_off_addr_out,
  output logic [N_STAGE-1:0]            key_off_valid_out,
  output logic [1:0]                    cur_owner,
  output logic                          err_bad_stage,
  output logic                          err_lock_tmo,
  input  logic                          err_clr
`ifdef KEY_OFF_WR_CNT_EN
  ,
  output logic [15:0]                   wr_cnt0,
  output logic [15:0]                   wr_cnt1
`endif
);

  // State encoding doubles as the cur_owner code.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOCK0 = 2'b01;
  localparam logic [1:0] ST_LOCK1 = 2'b10;

  localparam logic [AXIL_WIDTH-1:0] ENTRY_MASK =
    {{(AXIL_WIDTH - KEY_OFF){1'b0}}, {KEY_OFF{1'b1}}};
  localparam logic [7:0] TMO_LIMIT = 8'(LOCK_TMO);

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic [1:0]                    state_q, state_d;
  logic                          rr_ptr_q, rr_ptr_d;   // 0: req0 preferred, 1: req1 preferred
  logic [7:0]                    tmo_cnt_q, tmo_cnt_d;
  logic [AXIL_WIDTH-1:0]         entry_q, entry_d;
  logic [KEY_OFF_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [N_STAGE-1:0]            valid_q, valid_d;
  logic                          err_bad_q, err_bad_d;
  logic                          err_tmo_q, err_tmo_d;

  // ---------------------------------------------------------------------------------------------
  // Grant / ready
  // ---------------------------------------------------------------------------------------------
  logic rdy0, rdy1;
  logic acc0, acc1, accept;

  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (req0_valid && (!req1_valid || !rr_ptr_q)) begin
            rdy0 = 1'b1;
          end else if (req1_valid) begin
            rdy1 = 1'b1;
          end
        end
        // The lock owner is always ready; the other side is held off.
        ST_LOCK0: rdy0 = 1'b1;
        ST_LOCK1: rdy1 = 1'b1;
        default: begin
          rdy0 = 1'b0;
          rdy1 = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = rdy0;
  assign req1_ready = rdy1;
  assign acc0       = rdy0 & req0_valid;
  assign acc1       = rdy1 & req1_valid;
  assign accept     = acc0 | acc1;

  // ---------------------------------------------------------------------------------------------
  // Beat selection and stage decode
  // ---------------------------------------------------------------------------------------------
  logic [STAGE_ID_WIDTH-1:0]     sel_stage;
  logic [KEY_OFF_ADDR_WIDTH-1:0] sel_addr;
  logic [AXIL_WIDTH-1:0]         sel_data;
  logic                          stage_ok;
  logic [N_STAGE-1:0]            strobe;

  assign sel_stage = acc1 ? req1_stage : req0_stage;
  assign sel_addr  = acc1 ? req1_addr  : req0_addr;
  assign sel_data  = acc1 ? req1_data  : req0_data;
  assign stage_ok  = 32'(sel_stage) < N_STAGE;

  always_comb begin
    strobe = '0;
    for (int unsigned i = 0; i < N_STAGE; i++) begin
      strobe[i] = accept && (32'(sel_stage) == i);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Arbitration FSM, round-robin pointer and lock timeout
  // ---------------------------------------------------------------------------------------------
  logic tmo_fire;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        if (acc0) begin
          if (req0_lock) state_d  = ST_LOCK0;
          else           rr_ptr_d = 1'b1;
        end else if (acc1) begin
          if (req1_lock) state_d  = ST_LOCK1;
          else           rr_ptr_d = 1'b0;
        end
      end
      ST_LOCK0: begin
        if (acc0) begin
          tmo_cnt_d = '0;
          if (!req0_lock) begin
            state_d  = ST_IDLE;
            rr_ptr_d = 1'b1;
          end
        end else begin
          // The cycle in which the stall count reaches the limit performs the release.
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_d == TMO_LIMIT) begin
            state_d   = ST_IDLE;
            rr_ptr_d  = 1'b1;
            tmo_cnt_d = '0;
            tmo_fire  = 1'b1;
          end
        end
      end
      ST_LOCK1: begin
        if (acc1) begin
          tmo_cnt_d = '0;
          if (!req1_lock) begin
            state_d  = ST_IDLE;
            rr_ptr_d = 1'b0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_d == TMO_LIMIT) begin
            state_d   = ST_IDLE;
            rr_ptr_d  = 1'b0;
            tmo_cnt_d = '0;
            tmo_fire  = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tmo_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Write port and sticky errors
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    entry_d = entry_q;
    addr_d  = addr_q;
    valid_d = strobe;
    if (accept) begin
      entry_d = sel_data & ENTRY_MASK;
      addr_d  = sel_addr;
    end
  end

  // Setting wins over a same-cycle clear.
  assign err_bad_d = (err_bad_q & ~err_clr) | (accept & ~stage_ok);
  assign err_tmo_d = (err_tmo_q & ~err_clr) | tmo_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= 1'b0;
      tmo_cnt_q <= '0;
      entry_q   <= '0;
      addr_q    <= '0;
      valid_q   <= '0;
      err_bad_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      entry_q   <= entry_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      err_bad_q <= err_bad_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign key_off_entry_out = entry_q;
  assign key_off_addr_out  = addr_q;
  assign key_off_valid_out = valid_q;
  assign cur_owner         = state_q;
  assign err_bad_stage     = err_bad_q;
  assign err_lock_tmo      = err_tmo_q;

`ifdef KEY_OFF_WR_CNT_EN
  // ---------------------------------------------------------------------------------------------
  // Per-requester strobed-write counters
  // ---------------------------------------------------------------------------------------------
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (err_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (acc0 && stage_ok) cnt0_d = cnt0_q + 16'd1;
      if (acc1 && stage_ok) cnt1_d = cnt1_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign wr_cnt0 = cnt0_q;
  assign wr_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_key_off_cfg_arbiter.sv
// Directed bench for key_off_cfg_arbiter. Expected write beats are queued when driven and
// compared one cycle later when the registered write port presents them.

module tb_key_off_cfg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_lock;
  logic [2:0]  req0_stage;
  logic [3:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready, req1_lock;
  logic [2:0]  req1_stage;
  logic [3:0]  req1_addr;
  logic [31:0] req1_data;
  logic [31:0] key_off_entry_out;
  logic [3:0]  key_off_addr_out;
  logic [4:0]  key_off_valid_out;
  logic [1:0]  cur_owner;
  logic        err_bad_stage, err_lock_tmo, err_clr;
`ifdef KEY_OFF_WR_CNT_EN
  logic [15:0] wr_cnt0, wr_cnt1;
`endif

  always #5 clk = ~clk;

  key_off_cfg_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .req0_valid        (req0_valid),
    .req0_ready        (req0_ready),
    .req0_stage        (req0_stage),
    .req0_addr         (req0_addr),
    .req0_data         (req0_data),
    .req0_lock         (req0_lock),
    .req1_valid        (req1_valid),
    .req1_ready        (req1_ready),
    .req1_stage        (req1_stage),
    .req1_addr         (req1_addr),
    .req1_data         (req1_data),
    .req1_lock         (req1_lock),
    .key_off_entry_out (key_off_entry_out),
    .key_off_addr_out  (key_off_addr_out),
    .key_off_valid_out (key_off_valid_out),
    .cur_owner         (cur_owner),
    .err_bad_stage     (err_bad_stage),
    .err_lock_tmo      (err_lock_tmo),
    .err_clr           (err_clr)
`ifdef KEY_OFF_WR_CNT_EN
    ,
    .wr_cnt0           (wr_cnt0),
    .wr_cnt1           (wr_cnt1)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  vo;
    logic [3:0]  addr;
    logic [31:0] entry;
    bit          chk;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected write-port contents for an accepted beat.
  function automatic exp_t model(input logic [2:0] s, input logic [3:0] a, input logic [31:0] d);
    exp_t e;
    e.vo    = (s < 3'd5) ? (5'b00001 << s) : 5'b00000;
    e.addr  = a;
    e.entry = d & 32'h0003_FFFF;
    e.chk   = (s < 3'd5);
    return e;
  endfunction

  // One cycle: drive both requesters, check readies, queue the expected beat, check it after
  // the edge. Called at posedge+1.
  task automatic cyc(input string tag,
                     input logic v0, input logic [2:0] s0, input logic [3:0] a0,
                     input logic [31:0] d0, input logic l0,
                     input logic v1, input logic [2:0] s1, input logic [3:0] a1,
                     input logic [31:0] d1, input logic l1,
                     input logic er0, input logic er1);
    exp_t e;
    req0_valid = v0; req0_stage = s0; req0_addr = a0; req0_data = d0; req0_lock = l0;
    req1_valid = v1; req1_stage = s1; req1_addr = a1; req1_data = d1; req1_lock = l1;
    #1;
    check({tag, ".rdy0"}, 32'(req0_ready), 32'(er0));
    check({tag, ".rdy1"}, 32'(req1_ready), 32'(er1));
    if (v0 && er0) begin
      sb.push_back(model(s0, a0, d0));
    end else if (v1 && er1) begin
      sb.push_back(model(s1, a1, d1));
    end else begin
      e.vo = '0; e.addr = '0; e.entry = '0; e.chk = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".vld"}, 32'(key_off_valid_out), 32'(e.vo));
    if (e.chk) begin
      check({tag, ".addr"}, 32'(key_off_addr_out), 32'(e.addr));
      check({tag, ".entry"}, key_off_entry_out, e.entry);
    end
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; err_clr = 1'b0;
    req0_valid = 1'b1; req0_stage = '0; req0_addr = '0; req0_data = '0; req0_lock = 1'b0;
    req1_valid = 1'b1; req1_stage = '0; req1_addr = '0; req1_data = '0; req1_lock = 1'b0;
    #1;
    check("rst.rdy0", 32'(req0_ready), 32'd0);
    check("rst.rdy1", 32'(req1_ready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("rst.vld", 32'(key_off_valid_out), 32'd0);
    check("rst.entry", key_off_entry_out, 32'd0);
    check("rst.addr", 32'(key_off_addr_out), 32'd0);
    check("rst.owner", 32'(cur_owner), 32'd0);
    check("rst.ebad", 32'(err_bad_stage), 32'd0);
    check("rst.etmo", 32'(err_lock_tmo), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // 1: both valid, unlocked -> alternate starting with req0
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("t1.b%0d", i),
          1'b1, 3'd0, 4'd1, 32'hA5A5_1234 + 32'(i), 1'b0,
          1'b1, 3'd4, 4'hE, 32'h1234_5678 + 32'(i), 1'b0,
          (i % 2) == 0, (i % 2) == 1);
    end

    // 2: data above KEY_OFF masked, one-hot strobe, then hold on idle
    cyc("t2.wr", 1'b0, 3'd0, 4'd0, 32'd0, 1'b0,
        1'b1, 3'd2, 4'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    idle("t2.idle");
    check("t2.hold.addr", 32'(key_off_addr_out), 32'd5);
    check("t2.hold.entry", key_off_entry_out, 32'h0003_FFFF);

    // 3: req0 locked burst holds req1 off
    cyc("t3.b0", 1'b1, 3'd1, 4'd2, 32'h0000_1000, 1'b1,
        1'b1, 3'd3, 4'd7, 32'h0000_2000, 1'b0, 1'b1, 1'b0);
    check("t3.owner0", 32'(cur_owner), 32'd1);
    cyc("t3.b1", 1'b1, 3'd1, 4'd3, 32'h0000_1001, 1'b1,
        1'b1, 3'd3, 4'd7, 32'h0000_2000, 1'b0, 1'b1, 1'b0);
    cyc("t3.b2", 1'b1, 3'd1, 4'd4, 32'h0000_1002, 1'b1,
        1'b1, 3'd3, 4'd7, 32'h0000_2000, 1'b0, 1'b1, 1'b0);
    check("t3.owner2", 32'(cur_owner), 32'd1);
    cyc("t3.b3", 1'b1, 3'd1, 4'd5, 32'h0000_1003, 1'b0,
        1'b1, 3'd3, 4'd7, 32'h0000_2000, 1'b0, 1'b1, 1'b0);
    check("t3.owner3", 32'(cur_owner), 32'd0);
    cyc("t3.r1", 1'b1, 3'd1, 4'd6, 32'h0000_1004, 1'b0,
        1'b1, 3'd3, 4'd7, 32'h0000_2000, 1'b0, 1'b0, 1'b1);

    // 4: req0 locks, then stalls until forced release
    cyc("t4.lock", 1'b1, 3'd0, 4'd9, 32'h0000_0ABC, 1'b1,
        1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 254; i++) begin
      cyc($sformatf("t4.w%0d", i), 1'b0, 3'd0, 4'd0, 32'd0, 1'b0,
          1'b1, 3'd3, 4'd8, 32'h0000_0DEF, 1'b0, 1'b1, 1'b0);
    end
    check("t4.owner254", 32'(cur_owner), 32'd1);
    check("t4.etmo254", 32'(err_lock_tmo), 32'd0);
    cyc("t4.w254", 1'b0, 3'd0, 4'd0, 32'd0, 1'b0,
        1'b1, 3'd3, 4'd8, 32'h0000_0DEF, 1'b0, 1'b1, 1'b0);
    check("t4.owner255", 32'(cur_owner), 32'd0);
    check("t4.etmo255", 32'(err_lock_tmo), 32'd1);
    cyc("t4.r1", 1'b1, 3'd0, 4'd1, 32'h0000_0111, 1'b0,
        1'b1, 3'd3, 4'd8, 32'h0000_0DEF, 1'b0, 1'b0, 1'b1);

    // 5: bad stage accepted without strobe; sticky error and set-wins-over-clear
    cyc("t5.bad7", 1'b1, 3'd7, 4'd2, 32'h0000_0077, 1'b0,
        1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t5.ebad7", 32'(err_bad_stage), 32'd1);
    err_clr = 1'b1;
    idle("t5.clr");
    err_clr = 1'b0;
    check("t5.clr.ebad", 32'(err_bad_stage), 32'd0);
    check("t5.clr.etmo", 32'(err_lock_tmo), 32'd0);
    cyc("t5.bad5", 1'b1, 3'd5, 4'd3, 32'h0000_0055, 1'b0,
        1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t5.ebad5", 32'(err_bad_stage), 32'd1);
    err_clr = 1'b1;
    cyc("t5.bad6clr", 1'b0, 3'd0, 4'd0, 32'd0, 1'b0,
        1'b1, 3'd6, 4'd4, 32'h0000_0066, 1'b1, 1'b0, 1'b1);
    err_clr = 1'b0;
    check("t5.ebad6", 32'(err_bad_stage), 32'd1);
    check("t5.owner", 32'(cur_owner), 32'd2);

    // 6: reset while req1 holds the lock, beat presented during reset is dropped
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_stage = 3'd1; req1_addr = 4'd3; req1_data = 32'h0000_3333;
    req1_lock = 1'b0;
    rst = 1'b1;
    #1;
    check("t6.rdy1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6.vld", 32'(key_off_valid_out), 32'd0);
    check("t6.entry", key_off_entry_out, 32'd0);
    check("t6.addr", 32'(key_off_addr_out), 32'd0);
    check("t6.owner", 32'(cur_owner), 32'd0);
    check("t6.ebad", 32'(err_bad_stage), 32'd0);
    cyc("t6.rr", 1'b1, 3'd0, 4'd6, 32'h0000_6000, 1'b0,
        1'b1, 3'd1, 4'd3, 32'h0000_3333, 1'b0, 1'b1, 1'b0);

`ifdef KEY_OFF_WR_CNT_EN
    check("cnt.first", 32'(wr_cnt0), 32'd1);
    err_clr = 1'b1;
    idle("cnt.clr");
    err_clr = 1'b0;
    check("cnt.clr0", 32'(wr_cnt0), 32'd0);
    cyc("cnt.g0", 1'b1, 3'd0, 4'd1, 32'd1, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc("cnt.g1", 1'b1, 3'd1, 4'd2, 32'd2, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc("cnt.bad", 1'b1, 3'd7, 4'd3, 32'd3, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc("cnt.g2", 1'b1, 3'd3, 4'd4, 32'd4, 1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("cnt.wr0", 32'(wr_cnt0), 32'd3);
    check("cnt.wr1", 32'(wr_cnt1), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
